uart_boot_loader: RTL and testbench

Serial boot loader that sits downstream of `uart_wrapper` and acts as its AXI4-Lite read master. It polls the UART status register, pops received bytes, assembles little-endian 32-bit instruction words and writes them into instruction memory. When the image is complete it releases the CPU from reset.

---
 rtl/uart_boot_pkg.sv | 26 ++
 rtl/boot_word_assembler.sv | 44 ++++
 rtl/uart_boot_loader.sv | 206 ++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
// uart_boot_pkg: shared definitions for the UART serial boot loader.
//   - boot_state_e        : loader FSM states
//   - RXDATA_ADDR_DEF     : default UART RX data register offset (read pops a byte)
//   - STATUS_ADDR_DEF     : default UART status register offset
//   - AXI_RESP_OKAY       : the only read response accepted as good
//   - STATUS_RX_VALID_BIT : status bit that flags a byte waiting in the UART
package uart_boot_pkg;

    localparam logic [3:0] RXDATA_ADDR_DEF     = 4'h0;
    localparam logic [3:0] STATUS_ADDR_DEF     = 4'h8;
    localparam logic [1:0] AXI_RESP_OKAY       = 2'b00;
    localparam int         STATUS_RX_VALID_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL_AR,
        ST_POLL_R,
        ST_GAP,
        ST_DATA_AR,
        ST_DATA_R,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

endpackage

// File: rtl/boot_word_assembler.sv
// boot_word_assembler: shifts received bytes into a little-endian 32-bit word.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   clear         : drop any partial word (start of a new load)
//   byte_valid    : byte_in is absorbed this cycle
//   byte_in       : received byte
//   word          : assembled word, complete in the cycle word_valid is high
//   word_valid    : one-cycle pulse the cycle after the fourth byte
//   last_byte     : the next absorbed byte completes a word
module boot_word_assembler (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    logic [1:0] byte_cnt;

    assign last_byte = (byte_cnt == 2'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word       <= '0;
            byte_cnt   <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                word     <= '0;
                byte_cnt <= '0;
            end else if (byte_valid) begin
                // LSB arrives first, so new bytes enter at the top and slide down.
                word       <= {byte_in, word[31:8]};
                byte_cnt   <= byte_cnt + 2'd1;
                word_valid <= last_byte;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: AXI4-Lite read master that drains uart_wrapper, assembles
// a boot image (word count N, then N little-endian words) and writes it into
// instruction memory, then releases the CPU from reset.
// Optional feature: define UART_BOOT_CHECKSUM_EN to expect a trailing word
// equal to the mod-2**32 sum of the N data words.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   start                : pulse, begins a load when idle
//   m_axi_ar* / m_axi_r* : AXI4-Lite read channels towards uart_wrapper
//   imem_we/addr/wdata   : instruction memory write port
//   busy, done, error    : load status (done/error sticky until reset)
//   cpu_resetn           : CPU reset, released once the image is loaded
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int         IMEM_AW     = 10,
    parameter logic [3:0] RXDATA_ADDR = RXDATA_ADDR_DEF,
    parameter logic [3:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter int         POLL_GAP    = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    output logic [3:0]         m_axi_araddr,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [31:0]        m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_resetn
);

    localparam int          CW    = IMEM_AW + 1;
    localparam int          GAP_W = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [31:0] DEPTH = 32'(2 ** IMEM_AW);

    boot_state_e      state;
    logic [GAP_W-1:0] gap_cnt;
    logic [CW-1:0]    word_cnt;     // N, valid once count_loaded
    logic [CW-1:0]    wr_cnt;       // data words written so far
    logic             count_loaded;
`ifdef UART_BOOT_CHECKSUM_EN
    logic [31:0]      sum;
`endif

    logic        resp_ok, byte_valid, asm_clear, asm_last, asm_word_valid, in_data;
    logic [31:0] asm_word;
    logic        unused_rdata;

    assign resp_ok      = (m_axi_rresp == AXI_RESP_OKAY);
    // Bytes with a bad response never reach the assembler.
    assign byte_valid   = (state == ST_DATA_R) && m_axi_rvalid && m_axi_rready && resp_ok;
    assign asm_clear    = (state == ST_IDLE) && start;
    assign in_data      = count_loaded && (wr_cnt != word_cnt);
    assign imem_addr    = wr_cnt[IMEM_AW-1:0];
    assign imem_wdata   = asm_word;
    assign unused_rdata = ^m_axi_rdata[31:8];

    boot_word_assembler u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (asm_clear),
        .byte_valid (byte_valid),
        .byte_in    (m_axi_rdata[7:0]),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .last_byte  (asm_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            imem_we       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            cpu_resetn    <= 1'b0;
            gap_cnt       <= '0;
            word_cnt      <= '0;
            wr_cnt        <= '0;
            count_loaded  <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state         <= ST_POLL_AR;
                    busy          <= 1'b1;
                    m_axi_arvalid <= 1'b1;
                    m_axi_araddr  <= STATUS_ADDR;
                end
                ST_POLL_AR, ST_DATA_AR: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= (state == ST_POLL_AR) ? ST_POLL_R : ST_DATA_R;
                end
                ST_POLL_R: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    if (!resp_ok) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (m_axi_rdata[STATUS_RX_VALID_BIT]) begin
                        state         <= ST_DATA_AR;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= RXDATA_ADDR;
                    end else begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
                        state         <= ST_POLL_AR;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STATUS_ADDR;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                ST_DATA_R: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    if (!resp_ok) begin
                        state <= ST_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (asm_last) begin
                        // Only data words reach memory; count and trailer words do not.
                        state   <= ST_WRITE;
                        imem_we <= in_data;
                    end else begin
                        state         <= ST_POLL_AR;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= STATUS_ADDR;
                    end
                end
                ST_WRITE: if (asm_word_valid) begin
                    state         <= ST_POLL_AR;
                    m_axi_arvalid <= 1'b1;
                    m_axi_araddr  <= STATUS_ADDR;
                    if (!count_loaded) begin
                        count_loaded <= 1'b1;
                        word_cnt     <= asm_word[CW-1:0];
                        if (asm_word == '0) begin
                            state         <= ST_DONE;
                            m_axi_arvalid <= 1'b0;
                            done          <= 1'b1;
                            cpu_resetn    <= 1'b1;
                            busy          <= 1'b0;
                        end else if (asm_word > DEPTH) begin
                            state         <= ST_ERROR;
                            m_axi_arvalid <= 1'b0;
                            error         <= 1'b1;
                            busy          <= 1'b0;
                        end
                    end else if (in_data) begin
                        wr_cnt <= wr_cnt + CW'(1);
`ifdef UART_BOOT_CHECKSUM_EN
                        sum    <= sum + asm_word;
`else
                        if (wr_cnt + CW'(1) == word_cnt) begin
                            state         <= ST_DONE;
                            m_axi_arvalid <= 1'b0;
                            done          <= 1'b1;
                            cpu_resetn    <= 1'b1;
                            busy          <= 1'b0;
                        end
`endif
                    end else begin
                        // Trailer word: only reachable with the checksum build.
                        m_axi_arvalid <= 1'b0;
                        busy          <= 1'b0;
`ifdef UART_BOOT_CHECKSUM_EN
                        if (asm_word == sum) begin
                            state      <= ST_DONE;
                            done       <= 1'b1;
                            cpu_resetn <= 1'b1;
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
`else
                        state <= ST_ERROR;
                        error <= 1'b1;
`endif
                    end
                end
                ST_DONE, ST_ERROR: ;
                default: state <= ST_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: bench for uart_boot_loader. A UART/AXI-Lite slave model
// serves bytes from a queue; expected memory writes are queued as each image
// is built and popped by a write monitor.
module tb_uart_boot_loader;

    localparam int         IMEM_AW  = 10;
    localparam int         POLL_GAP = 4;
    localparam logic [3:0] ST_ADDR  = 4'h8;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic               clk, resetn, start;
    logic [3:0]         m_axi_araddr;
    logic               m_axi_arvalid, m_axi_arready;
    logic [31:0]        m_axi_rdata;
    logic [1:0]         m_axi_rresp;
    logic               m_axi_rvalid, m_axi_rready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_wdata;
    logic               busy, done, error, cpu_resetn;

    int vectors = 0, miscompares = 0;
    int cyc = 0, pops = 0, queued = 0, empty_polls = 0, silence = 0, gap_len = 0;
    int err_at_pop = -1, ar_delay_max = 0;
    int data_set_cyc = 0, empty_cyc = 0, last_we_cyc = 0, end_cyc = 0;
    bit after_empty = 0;

    logic [7:0]  rx_q[$];
    wr_t         exp_q[$];
    logic [31:0] img[$];

    uart_boot_loader #(.IMEM_AW(IMEM_AW), .RXDATA_ADDR(4'h0), .STATUS_ADDR(ST_ADDR),
                       .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error), .cpu_resetn(cpu_resetn)
    );

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever begin @(posedge clk); cyc++; end

    // UART register model behind an AXI-Lite read slave.
    initial begin
        int sst, dly;
        logic [3:0] addr_l;
        bit ar_seen, rv;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
        sst = 0; dly = 0; ar_seen = 0; addr_l = '0;
        forever begin
            @(negedge clk);
            if (silence > 0) silence--;
            if (!resetn) begin
                m_axi_arready = 0; m_axi_rvalid = 0; sst = 0; ar_seen = 0; after_empty = 0; dly = 0;
            end else begin
                case (sst)
                    0: if (m_axi_arvalid) begin
                        if (!ar_seen) begin
                            ar_seen = 1; addr_l = m_axi_araddr;
                            if (after_empty) begin
                                after_empty = 0;
                                vectors++;
                                if (cyc - empty_cyc != POLL_GAP + 1) begin
                                    miscompares++;
                                    $display("FAIL poll_gap got=%0d want=%0d", cyc - empty_cyc, POLL_GAP + 1);
                                end
                            end
                        end else begin
                            vectors++;
                            if (m_axi_araddr !== addr_l) begin
                                miscompares++;
                                $display("FAIL araddr_stable got=%h want=%h", m_axi_araddr, addr_l);
                            end
                        end
                        if (dly == 0) begin m_axi_arready = 1; sst = 1; end
                        else dly--;
                    end
                    1: begin
                        m_axi_arready = 0; ar_seen = 0;
                        dly = int'($urandom_range(0, ar_delay_max));
                        vectors++;
                        if (m_axi_rready !== 1'b1) begin
                            miscompares++;
                            $display("FAIL rready_after_ar got=%b want=1", m_axi_rready);
                        end
                        if (addr_l == ST_ADDR) begin
                            rv = (rx_q.size() > 0) && (silence == 0);
                            m_axi_rdata = {31'd0, rv}; m_axi_rresp = 2'b00;
                            if (!rv) begin after_empty = 1; empty_cyc = cyc; empty_polls++; end
                        end else begin
                            vectors++;
                            if (rx_q.size() == 0) begin
                                miscompares++;
                                $display("FAIL rx_underflow got=pop want=no_pop");
                                m_axi_rdata = '0;
                            end else begin
                                m_axi_rdata = {24'd0, rx_q.pop_front()};
                            end
                            m_axi_rresp = (pops == err_at_pop) ? 2'b10 : 2'b00;
                            pops++; silence = gap_len; data_set_cyc = cyc;
                        end
                        m_axi_rvalid = 1; sst = 2;
                    end
                    default: begin m_axi_rvalid = 0; sst = 0; end
                endcase
            end
        end
    end

    // Write monitor: every imem_we must match the next expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (resetn && imem_we) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected got=%0d:%h want=none", imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                        miscompares++;
                        $display("FAIL write got=%0d:%h want=%0d:%h", imem_addr, imem_wdata, e.addr, e.data);
                    end
                end
                vectors++;
                if (cyc != data_set_cyc + 1) begin
                    miscompares++;
                    $display("FAIL we_latency got=%0d want=%0d", cyc - data_set_cyc, 1);
                end
                last_we_cyc = cyc;
            end
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) rx_q.push_back(w[8*b +: 8]);
        queued += 4;
    endtask

    task automatic queue_image();
        logic [31:0] s;
        s = '0;
        push_word(32'(img.size()));
        foreach (img[i]) begin
            push_word(img[i]);
            exp_q.push_back('{addr: 10'(i), data: img[i]});
            s += img[i];
        end
`ifdef UART_BOOT_CHECKSUM_EN
        if (img.size() != 0) push_word(s);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk); resetn = 0; start = 0;
        repeat (3) @(negedge clk);
        rx_q.delete(); exp_q.delete(); img.delete();
        pops = 0; queued = 0; empty_polls = 0; silence = 0; gap_len = 0;
        err_at_pop = -1; ar_delay_max = 0;
        @(negedge clk); resetn = 1;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
    endtask

    task automatic wait_end(input int budget);
        int k;
        k = 0;
        while (!(done || error) && k < budget) begin @(negedge clk); k++; end
        end_cyc = cyc;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({m_axi_arvalid, m_axi_rready, m_axi_araddr, imem_we, imem_addr, imem_wdata,
             busy, done, error, cpu_resetn} !== 53'd0) begin
            miscompares++;
            $display("FAIL reset_values got=%h want=0", {m_axi_arvalid, m_axi_rready, m_axi_araddr,
                     imem_we, imem_addr, imem_wdata, busy, done, error, cpu_resetn});
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (m_axi_arvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start got=%b%b want=00", m_axi_arvalid, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        img.push_back(32'hA1B2C3D4);
        queue_image();
        pulse_start();
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_rise got=%b want=1", busy); end
        wait_end(3000);
        vectors++;
        if ({done, error, cpu_resetn, busy} !== 4'b1010) begin
            miscompares++;
            $display("FAIL single_status got=%b want=1010", {done, error, cpu_resetn, busy});
        end
        vectors++;
        if (exp_q.size() != 0 || pops != queued) begin
            miscompares++;
            $display("FAIL single_writes got=%0d/%0d want=0/%0d", exp_q.size(), pops, queued);
        end
`ifndef UART_BOOT_CHECKSUM_EN
        vectors++;
        if (end_cyc != last_we_cyc + 1) begin
            miscompares++;
            $display("FAIL done_latency got=%0d want=1", end_cyc - last_we_cyc);
        end
`endif
    endtask

    task automatic test_zero_count();
        do_reset();
        queue_image();
        pulse_start();
        wait_end(1000);
        vectors++;
        if ({done, error, cpu_resetn} !== 3'b101 || pops != 4) begin
            miscompares++;
            $display("FAIL zero_count got=%b pops=%0d want=101 pops=4", {done, error, cpu_resetn}, pops);
        end
    endtask

    task automatic test_gap();
        do_reset();
        gap_len = 20;
        img.push_back(32'h11112222); img.push_back(32'h33334444); img.push_back(32'hDEADBEEF);
        queue_image();
        pulse_start();
        wait_end(8000);
        vectors++;
        if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL gap_done got=%b left=%0d want=10 left=0", {done, error}, exp_q.size());
        end
        vectors++;
        if (pops != queued || rx_q.size() != 0 || empty_polls == 0) begin
            miscompares++;
            $display("FAIL gap_pops got=%0d empty=%0d want=%0d empty>0", pops, empty_polls, queued);
        end
    endtask

    task automatic test_too_big();
        do_reset();
        push_word(32'h00000401);
        pulse_start();
        wait_end(1000);
        vectors++;
        if ({done, error, cpu_resetn, busy} !== 4'b0100 || pops != 4) begin
            miscompares++;
            $display("FAIL too_big got=%b pops=%0d want=0100 pops=4", {done, error, cpu_resetn, busy}, pops);
        end
    endtask

    task automatic test_slverr();
        do_reset();
        push_word(32'd1); push_word(32'h01020304);
        err_at_pop = 5;
        pulse_start();
        wait_end(1000);
        vectors++;
        if ({done, error, cpu_resetn} !== 3'b010 || pops != 6) begin
            miscompares++;
            $display("FAIL slverr got=%b pops=%0d want=010 pops=6", {done, error, cpu_resetn}, pops);
        end
        pulse_start();
        repeat (10) @(negedge clk);
        vectors++;
        if ({busy, m_axi_arvalid, error} !== 3'b001 || pops != 6) begin
            miscompares++;
            $display("FAIL start_after_error got=%b pops=%0d want=001 pops=6", {busy, m_axi_arvalid, error}, pops);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_reset();
        img.push_back(32'h11223344);
        queue_image();
        pulse_start();
        k = 0;
        while (pops < 6 && k < 1000) begin @(negedge clk); k++; end
        vectors++;
        if (pops < 6) begin miscompares++; $display("FAIL mid_progress got=%0d want=6", pops); end
        do_reset();
        img.push_back(32'h5A5A5A5A);
        queue_image();
        pulse_start();
        wait_end(3000);
        vectors++;
        if ({done, error} !== 2'b10 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL reset_mid got=%b left=%0d want=10 left=0", {done, error}, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ar_delay_max = 2;
        for (int i = 0; i < 4; i++) img.push_back($urandom);
        queue_image();
        pulse_start();
        wait_end(6000);
        vectors++;
        if ({done, error, cpu_resetn} !== 3'b101 || exp_q.size() != 0 || pops != queued) begin
            miscompares++;
            $display("FAIL b2b got=%b left=%0d pops=%0d want=101 left=0 pops=%0d",
                     {done, error, cpu_resetn}, exp_q.size(), pops, queued);
        end
    endtask

`ifdef UART_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            push_word(32'd2); push_word(32'd1); push_word(32'd2);
            push_word((t == 0) ? 32'd3 : 32'd4);
            exp_q.push_back('{addr: 10'd0, data: 32'd1});
            exp_q.push_back('{addr: 10'd1, data: 32'd2});
            pulse_start();
            wait_end(3000);
            vectors++;
            if ({done, error} !== ((t == 0) ? 2'b10 : 2'b01) || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL checksum_%0d got=%b left=%0d", t, {done, error}, exp_q.size());
            end
        end
    endtask
`endif

    initial begin
        resetn = 0; start = 0;
        test_reset();
        test_single();
        test_zero_count();
        test_gap();
        test_too_big();
        test_slverr();
        test_reset_mid();
        test_back_to_back();
`ifdef UART_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
